// File: rtl/ii_fetch_pkg.sv
// Shared integral-image geometry and the read-tag type carried down the fetch pipeline.
package ii_fetch_pkg;

  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int W_X        = $clog2(IMG_WIDTH);
  localparam int W_Y        = $clog2(IMG_HEIGHT);
  localparam int W_ADDR     = $clog2(IMG_WIDTH * IMG_HEIGHT);

  typedef struct packed {
    logic vld;
    logic oob;
  } rd_tag_t;

  // Row-major linear address, evaluated and truncated at W_ADDR bits.
  function automatic logic [W_ADDR-1:0] lin_addr(input logic [W_X-1:0] x,
                                                 input logic [W_Y-1:0] y);
    return W_ADDR'(y) * W_ADDR'(IMG_WIDTH) + W_ADDR'(x);
  endfunction

endpackage

// File: rtl/ii_fetch_if.sv
// Request (x,y) stream from the window sweeper and response word stream to the evaluator.
interface ii_fetch_if import ii_fetch_pkg::*; #(
  parameter int DATA_WIDTH = 25
);
  logic                  addr_valid;
  logic                  addr_ready;
  logic [W_X-1:0]        x;
  logic [W_Y-1:0]        y;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output addr_valid, x, y, data_ready,
    input  addr_ready, data_valid, data
  );

  modport slave (
    input  addr_valid, x, y, data_ready,
    output addr_ready, data_valid, data
  );
endinterface

// File: rtl/ii_fetch_fifo.sv
// Synchronous FIFO for read results; DEPTH must be a power of two so pointers wrap freely.
module ii_fetch_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty/count gate what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ii_fetch.sv
// Integral-image read responder: (x,y) -> RAM read -> in-order, credit-limited response stream.
// Optional macro II_FETCH_BOUNDS_CHECK_EN: out-of-range requests return 0 and set sticky err.
module ii_fetch import ii_fetch_pkg::*; #(
  parameter int DATA_WIDTH  = 25,
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ii_fetch_if.slave             rd,
  output logic                  mem_rd_en,
  output logic [W_ADDR-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                    req_hs, oob, push, pop;
  logic                    fifo_empty, fifo_full, credit_ok;
  logic [CW-1:0]           fifo_count, inflight_q, inflight_d;
  logic [CW:0]             credits_used;
  logic                    mem_rd_en_q, mem_rd_en_d;
  logic [W_ADDR-1:0]       mem_addr_q, mem_addr_d;
  rd_tag_t [MEM_LATENCY:0] vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0]   fifo_din, fifo_dout;

`ifdef II_FETCH_BOUNDS_CHECK_EN
  assign oob = ({1'b0, rd.x} >= (W_X+1)'(IMG_WIDTH)) || ({1'b0, rd.y} >= (W_Y+1)'(IMG_HEIGHT));
`else
  assign oob = 1'b0;
`endif

  // Every accepted request holds a credit until its word leaves the FIFO, so the FIFO cannot overflow.
  assign credits_used  = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign credit_ok     = credits_used < (CW+1)'(FIFO_DEPTH);
  assign rd.addr_ready = !rst && credit_ok && !fifo_full;
  assign req_hs        = rd.addr_valid && rd.addr_ready;

  assign push          = vld_pipe_q[MEM_LATENCY].vld;
  assign fifo_din      = vld_pipe_q[MEM_LATENCY].oob ? '0 : mem_rdata;
  assign pop           = rd.data_valid && rd.data_ready;
  assign rd.data_valid = !fifo_empty;
  assign rd.data       = fifo_dout;

  assign mem_rd_en     = mem_rd_en_q;
  assign mem_addr      = mem_addr_q;

  always_comb begin
    mem_rd_en_d   = req_hs && !oob;
    mem_addr_d    = req_hs ? lin_addr(rd.x, rd.y) : mem_addr_q;
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[0] = rd_tag_t'{vld: req_hs, oob: oob};
    for (int i = 1; i <= MEM_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    inflight_d    = inflight_q + CW'(req_hs) - CW'(push);
  end

  // Clearing the tag pipe on reset is what discards reads still returning from the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      vld_pipe_q  <= '0;
      inflight_q  <= '0;
    end else begin
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      vld_pipe_q  <= vld_pipe_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef II_FETCH_BOUNDS_CHECK_EN
  logic err_q, err_d;

  always_comb err_d = err_q || (req_hs && oob);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  ii_fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_ii_fetch.sv
// Directed bench for ii_fetch: latency, streaming, backpressure, random traffic, reset, bounds.
`timescale 1ns/1ps
module tb_ii_fetch;
  import ii_fetch_pkg::*;

  localparam int DW    = 25;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] GARBAGE = 25'h1abcdef;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_rd_en;
  logic [W_ADDR-1:0] mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic              err;

  ii_fetch_if #(.DATA_WIDTH(DW)) bus();

  ii_fetch #(
    .DATA_WIDTH  (DW),
    .MEM_LATENCY (LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd        (bus),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: mem[a] = a, garbage when no read was issued.
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd_en ? DW'(mem_addr) : GARBAGE;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int xx, input int yy);
`ifdef II_FETCH_BOUNDS_CHECK_EN
    if (xx >= 320 || yy >= 240) return 0;
`endif
    return 32'((yy * 320 + xx) % 131072);
  endfunction

  // Scoreboard: expected words queued at handshake, checked at consumption.
  logic [31:0] sb[$];
  int outstanding = 0, over_cnt = 0, hs_total = 0, resp_total = 0;
  int last_resp_cyc = 0, dv_seen = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      sb.delete();
      outstanding = 0;
    end else begin
      if (outstanding > DEPTH) over_cnt++;
      if (bus.data_valid) dv_seen++;
      if (bus.addr_valid && bus.addr_ready) begin
        sb.push_back(exp_word(int'(bus.x), int'(bus.y)));
        outstanding++;
        hs_total++;
      end
      if (bus.data_valid && bus.data_ready) begin
        if (sb.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
        else                chk("rsp_data", 32'(bus.data), sb.pop_front());
        outstanding--;
        resp_total++;
        last_resp_cyc = cyc;
      end
    end
  end

  function automatic void gen(input int mode, input int k, output int cx, output int cy);
    case (mode)
      0:       begin cx = 5 + k % 25; cy = 7 + k / 25; end
      1:       begin cx = int'($urandom_range(319)); cy = int'($urandom_range(239)); end
      default: begin cx = 100 + k; cy = 100; end
    endcase
  endfunction

  task automatic run(input int n_req, input int pv, input int pr, input int mode,
                     input int budget, output int first_cyc, output int rdy_low);
    int k = 0, c = 0, cx, cy;
    rdy_low = 0;
    first_cyc = 0;
    gen(mode, 0, cx, cy);
    while (k < n_req && c < budget) begin
      @(posedge clk); #1;
      bus.addr_valid = (int'($urandom_range(99)) < pv);
      bus.data_ready = (int'($urandom_range(99)) < pr);
      bus.x = W_X'(cx);
      bus.y = W_Y'(cy);
      @(negedge clk);
      if (!bus.addr_ready) rdy_low++;
      if (bus.addr_valid && bus.addr_ready) begin
        if (k == 0) first_cyc = cyc;
        k++;
        gen(mode, k, cx, cy);
      end
      c++;
    end
    @(posedge clk); #1;
    bus.addr_valid = 1'b0;
    if (k < n_req) chk("run_timeout", 32'(k), 32'(n_req));
  endtask

  task automatic drain(input int budget);
    int c = 0;
    bus.addr_valid = 1'b0;
    bus.data_ready = 1'b1;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  int t0, low, r0, h0, d0, rd_cnt;

  initial begin
    rst = 1'b1;
    bus.addr_valid = 1'b0;
    bus.data_ready = 1'b0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ready", 32'(bus.addr_ready), 32'd0);
    chk("rst_rd_en",      32'(mem_rd_en), 32'd0);
    chk("rst_mem_addr",   32'(mem_addr), 32'd0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_err",        32'(err), 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.addr_ready), 32'd1);

    // Single request (3,2): address 643 out at t+1, response at t+3.
    @(posedge clk); #1;
    bus.addr_valid = 1'b1; bus.x = 9'd3; bus.y = 8'd2; bus.data_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(bus.addr_ready), 32'd1);
    @(posedge clk); #1;
    bus.addr_valid = 1'b0;
    @(negedge clk);
    chk("single_rd_en", 32'(mem_rd_en), 32'd1);
    chk("single_addr",  32'(mem_addr), 32'd643);
    chk("single_dv_t1", 32'(bus.data_valid), 32'd0);
    @(negedge clk);
    chk("single_rd_en_t2", 32'(mem_rd_en), 32'd0);
    chk("single_dv_t2", 32'(bus.data_valid), 32'd0);
    @(negedge clk);
    chk("single_dv_t3", 32'(bus.data_valid), 32'd1);
    chk("single_data",  32'(bus.data), 32'd643);
    drain(20);

    // 25x25 window, back-to-back at full rate.
    r0 = resp_total;
    run(625, 100, 100, 0, 700, t0, low);
    drain(20);
    chk("bb_ready_low", 32'(low), 32'd0);
    chk("bb_count",     32'(resp_total - r0), 32'd625);
    chk("bb_last_lat",  32'(last_resp_cyc - t0), 32'd627);

    // Backpressure: exactly DEPTH handshakes, then addr_ready held low.
    r0 = resp_total;
    h0 = hs_total;
    run(4, 100, 0, 2, 20, t0, low);
    bus.addr_valid = 1'b1; bus.x = 9'd100; bus.y = 8'd100; bus.data_ready = 1'b0;
    repeat (8) @(negedge clk);
    chk("stall_hs",    32'(hs_total - h0), 32'd4);
    chk("stall_ready", 32'(bus.addr_ready), 32'd0);
    chk("stall_dv",    32'(bus.data_valid), 32'd1);
    run(8, 100, 100, 2, 40, t0, low);
    drain(20);
    chk("stall_resume_cnt", 32'(resp_total - r0), 32'd12);

    // Random valid/ready at 50%.
    r0 = resp_total;
    run(10000, 50, 50, 1, 50000, t0, low);
    drain(40);
    chk("rand_cnt",    32'(resp_total - r0), 32'd10000);
    chk("credit_over", 32'(over_cnt), 32'd0);

    // Reset with two reads in flight and one word queued.
    run(3, 100, 0, 2, 20, t0, low);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pre_dv", 32'(bus.data_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.data_ready = 1'b1;
    d0 = dv_seen;
    r0 = resp_total;
    @(negedge clk);
    chk("rst_mid_ready", 32'(bus.addr_ready), 32'd1);
    chk("rst_mid_dv",    32'(bus.data_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("rst_mid_no_dv", 32'(dv_seen - d0), 32'd0);
    @(posedge clk); #1;
    bus.addr_valid = 1'b1; bus.x = 9'd10; bus.y = 8'd20;
    @(negedge clk);
    chk("rst_next_ready", 32'(bus.addr_ready), 32'd1);
    @(posedge clk); #1;
    bus.addr_valid = 1'b0;
    drain(20);
    chk("rst_next_cnt", 32'(resp_total - r0), 32'd1);

    // Column 320 is just past the right edge.
    r0 = resp_total;
    @(posedge clk); #1;
    bus.addr_valid = 1'b1; bus.x = 9'd320; bus.y = 8'd0;
    @(negedge clk);
    chk("oob_ready", 32'(bus.addr_ready), 32'd1);
    @(posedge clk); #1;
    bus.addr_valid = 1'b0;
    @(negedge clk);
`ifdef II_FETCH_BOUNDS_CHECK_EN
    chk("oob_rd_en", 32'(mem_rd_en), 32'd0);
    chk("oob_err",   32'(err), 32'd1);
`else
    chk("oob_rd_en", 32'(mem_rd_en), 32'd1);
    chk("oob_addr",  32'(mem_addr), 32'd320);
    chk("oob_err",   32'(err), 32'd0);
`endif
    rd_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_rd_en) rd_cnt++;
    end
    chk("oob_no_late_rd", 32'(rd_cnt), 32'd0);
    drain(20);
    chk("oob_rsp_cnt", 32'(resp_total - r0), 32'd1);
    run(2, 100, 100, 2, 20, t0, low);
    drain(20);
    repeat (5) @(negedge clk);
`ifdef II_FETCH_BOUNDS_CHECK_EN
    chk("err_sticky", 32'(err), 32'd1);
`else
    chk("err_final", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
